fir_stream_sink: RTL and testbench

Output-side buffer and frame monitor placed directly downstream of the FIR engine's AXI-Stream master port (sm_tvalid/sm_tdata/sm_tlast/sm_tready). It absorbs FIR output samples into a small first-word-fall-through FIFO, so downstream back-pressure does not stall the FIR pipeline immediately. It re-presents the samples on an AXI-Stream master port. It also checks each frame's length against the programmed data length and keeps a running sample count and checksum for firmware and testbench visibility.

---
 rtl/fir_stream_sink_if.sv | 18 +
 rtl/fir_stream_sink.sv | 151 +++++++++++++++
 tb/tb_fir_stream_sink.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/fir_stream_sink_if.sv
// fir_stream_sink_if
// AXI-Stream beat bundle (valid/data/last/ready) shared by the FIR output
// buffer's input and output sides.
//   tvalid : beat valid          (master -> slave)
//   tdata  : beat payload        (master -> slave)
//   tlast  : last beat of frame  (master -> slave)
//   tready : sink ready          (slave -> master)
interface fir_stream_sink_if #(
    parameter int pDATA_WIDTH = 32
);
    logic                   tvalid;
    logic [pDATA_WIDTH-1:0] tdata;
    logic                   tlast;
    logic                   tready;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/fir_stream_sink.sv
// fir_stream_sink
// Buffers FIR output samples in a small first-word-fall-through FIFO,
// re-presents them downstream, and monitors frame lengths against cfg_len
// while keeping a running sample count and checksum.
// Ports:
//   axis_clk, axis_rst_n : clock, async active-low reset
//   s_axis (slave)       : input stream from the FIR engine
//   m_axis (master)      : buffered output stream
//   cfg_len              : expected beats per frame, 0 = tlast only
//   clr                  : one-cycle clear of FIFO, monitor and status
//   frame_done           : one-cycle pulse after a frame-ending beat
//   len_err              : sticky frame-length mismatch
//   sample_cnt, checksum : accepted-beat count and sum (both wrap)
//   fifo_level           : entries held, 0..pDEPTH
//
// Frame monitor states:
//   state  | meaning
//   IDLE   | between frames, beat_cnt = 0
//   ACTIVE | inside a frame, beat_cnt = beats accepted so far
module fir_stream_sink #(
    parameter int pDATA_WIDTH = 32,
    parameter int pDEPTH      = 8,
    parameter int pCNT_WIDTH  = 16
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    fir_stream_sink_if.slave       s_axis,
    fir_stream_sink_if.master      m_axis,
    input  logic [pCNT_WIDTH-1:0]  cfg_len,
    input  logic                   clr,
    output logic                   frame_done,
    output logic                   len_err,
    output logic [pCNT_WIDTH-1:0]  sample_cnt,
    output logic [pDATA_WIDTH-1:0] checksum,
    output logic [pCNT_WIDTH-1:0]  fifo_level
);
    localparam int AW = $clog2(pDEPTH);
    localparam logic [AW-1:0]         PTR_ONE = 1;
    localparam logic [pCNT_WIDTH-1:0] CNT_ONE = 1;
    localparam logic [pCNT_WIDTH-1:0] LVL_MAX = pCNT_WIDTH'(pDEPTH);

    typedef enum logic {IDLE, ACTIVE} mon_state_t;

    logic [pDATA_WIDTH:0]  mem [pDEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [pCNT_WIDTH-1:0] level;
    logic                  push, pop, not_empty;

    mon_state_t            state_q, state_d;
    logic [pCNT_WIDTH-1:0] beat_cnt, beat_d;
    logic                  frame_end, err_set;

    // ---------------- FIFO ----------------
    assign not_empty     = (level != '0);
    assign s_axis.tready = (level != LVL_MAX);
    assign m_axis.tvalid = not_empty;
    // Head is gated so an empty FIFO presents zeros instead of stale storage.
    assign m_axis.tdata  = not_empty ? mem[rd_ptr][pDATA_WIDTH-1:0] : '0;
    assign m_axis.tlast  = not_empty ? mem[rd_ptr][pDATA_WIDTH]     : 1'b0;
    assign fifo_level    = level;

    assign push = s_axis.tvalid && s_axis.tready;
    assign pop  = not_empty && m_axis.tready;

    always_ff @(posedge axis_clk) begin
        if (push && !clr) begin
            mem[wr_ptr] <= {s_axis.tlast, s_axis.tdata};
        end
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   level <= level + CNT_ONE;
                2'b01:   level <= level - CNT_ONE;
                default: level <= level;
            endcase
        end
    end

    // ---------------- frame monitor ----------------
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_q  <= IDLE;
            beat_cnt <= '0;
        end else begin
            state_q  <= state_d;
            beat_cnt <= beat_d;
        end
    end

    always_comb begin
        logic [pCNT_WIDTH-1:0] beat_inc;
        logic                  len_hit;
        state_d   = state_q;
        beat_d    = beat_cnt;
        frame_end = 1'b0;
        err_set   = 1'b0;
        beat_inc  = (state_q == IDLE) ? CNT_ONE : beat_cnt + CNT_ONE;
        len_hit   = (beat_inc == cfg_len);
        if (push) begin
            if (s_axis.tlast || ((cfg_len != '0) && len_hit)) begin
                frame_end = 1'b1;
                state_d   = IDLE;
                beat_d    = '0;
                err_set   = (cfg_len != '0) && (s_axis.tlast ^ len_hit);
            end else begin
                state_d = ACTIVE;
                beat_d  = beat_inc;
            end
        end
        if (clr) begin
            state_d   = IDLE;
            beat_d    = '0;
            frame_end = 1'b0;
            err_set   = 1'b0;
        end
    end

    // ---------------- status ----------------
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            frame_done <= 1'b0;
            len_err    <= 1'b0;
            sample_cnt <= '0;
            checksum   <= '0;
        end else if (clr) begin
            frame_done <= 1'b0;
            len_err    <= 1'b0;
            sample_cnt <= '0;
            checksum   <= '0;
        end else begin
            frame_done <= frame_end;
            if (err_set) len_err <= 1'b1;
            if (push) begin
                sample_cnt <= sample_cnt + CNT_ONE;
                checksum   <= checksum + s_axis.tdata;
            end
        end
    end
endmodule

// File: tb/tb_fir_stream_sink.sv
module tb_fir_stream_sink;
    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int CW    = 16;

    logic          axis_clk = 1'b0;
    logic          axis_rst_n = 1'b0;
    logic [CW-1:0] cfg_len = '0;
    logic          clr = 1'b0;
    logic          frame_done, len_err;
    logic [CW-1:0] sample_cnt, fifo_level;
    logic [DW-1:0] checksum;

    fir_stream_sink_if #(.pDATA_WIDTH(DW)) s_if ();
    fir_stream_sink_if #(.pDATA_WIDTH(DW)) m_if ();

    fir_stream_sink #(.pDATA_WIDTH(DW), .pDEPTH(DEPTH), .pCNT_WIDTH(CW)) dut (
        .axis_clk   (axis_clk),
        .axis_rst_n (axis_rst_n),
        .s_axis     (s_if),
        .m_axis     (m_if),
        .cfg_len    (cfg_len),
        .clr        (clr),
        .frame_done (frame_done),
        .len_err    (len_err),
        .sample_cnt (sample_cnt),
        .checksum   (checksum),
        .fifo_level (fifo_level)
    );

    always #5 axis_clk = ~axis_clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: a queue of buffered beats plus frame bookkeeping.
    logic [DW:0]   mq[$];
    logic [CW-1:0] m_cnt;
    logic [DW-1:0] m_sum;
    int            m_n;
    bit            m_err, m_fd;

    task automatic model_reset();
        mq.delete();
        m_cnt = '0;
        m_sum = '0;
        m_n   = 0;
        m_err = 1'b0;
        m_fd  = 1'b0;
    endtask

    task automatic check_outputs(input string pfx);
        logic [DW:0] head;
        head = (mq.size() != 0) ? mq[0] : '0;
        check({pfx, "_s_tready"},  64'(s_if.tready), 64'(mq.size() != DEPTH));
        check({pfx, "_m_tvalid"},  64'(m_if.tvalid), 64'(mq.size() != 0));
        check({pfx, "_m_tdata"},   64'(m_if.tdata),  64'(head[DW-1:0]));
        check({pfx, "_m_tlast"},   64'(m_if.tlast),  64'(head[DW]));
        check({pfx, "_level"},     64'(fifo_level),  64'(mq.size()));
        check({pfx, "_sample_cnt"},64'(sample_cnt),  64'(m_cnt));
        check({pfx, "_checksum"},  64'(checksum),    64'(m_sum));
        check({pfx, "_len_err"},   64'(len_err),     64'(m_err));
        check({pfx, "_frame_done"},64'(frame_done),  64'(m_fd));
    endtask

    // Called at posedge+1: drive inputs, check at negedge, advance model, pass the edge.
    task automatic step(input bit sv, input logic [DW-1:0] d, input bit sl,
                        input bit mr, input bit c);
        bit do_push, do_pop, end_f;
        s_if.tvalid = sv;
        s_if.tdata  = d;
        s_if.tlast  = sl;
        m_if.tready = mr;
        clr         = c;
        @(negedge axis_clk);
        check_outputs("cyc");
        do_push = sv && (mq.size() != DEPTH);
        do_pop  = mr && (mq.size() != 0);
        if (c) begin
            model_reset();
        end else begin
            if (do_pop) void'(mq.pop_front());
            end_f = 1'b0;
            if (do_push) begin
                mq.push_back({sl, d});
                m_cnt = m_cnt + 16'd1;
                m_sum = m_sum + d;
                m_n++;
                end_f = sl || (cfg_len != 0 && m_n == int'(cfg_len));
                if (end_f) begin
                    if (cfg_len != 0 && (sl != (m_n == int'(cfg_len)))) m_err = 1'b1;
                    m_n = 0;
                end
            end
            m_fd = end_f;
        end
        @(posedge axis_clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b0;
        model_reset();
        repeat (3) @(posedge axis_clk);
        #2 axis_rst_n = 1'b1;
        @(posedge axis_clk);
        #1;

        // Reset state, then a clean 5-beat frame.
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        cfg_len = 16'd5;
        for (int i = 1; i <= 5; i++) step(1'b1, DW'(i), i == 5, 1'b1, 1'b0);
        idle(3);
        check("t1_sample_cnt", 64'(sample_cnt), 64'd5);
        check("t1_checksum",   64'(checksum),   64'd15);
        check("t1_len_err",    64'(len_err),    64'd0);

        // Fill under back-pressure, then drain.
        cfg_len = 16'd0;
        for (int i = 0; i < 12; i++) step(1'b1, DW'(32'h100 + i), 1'b0, 1'b0, 1'b0);
        check("t2_full_level", 64'(fifo_level),  64'(DEPTH));
        check("t2_full_ready", 64'(s_if.tready), 64'd0);
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("t2_drained", 64'(fifo_level), 64'd0);

        // Steady push+pop at level 3 across pointer wrap.
        for (int i = 0; i < 3; i++) step(1'b1, DW'(32'h200 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 24; i++) step(1'b1, DW'(32'h300 + i), 1'b0, 1'b1, 1'b0);
        check("t3_level", 64'(fifo_level), 64'd3);
        idle(5);

        // Short frame sets len_err, it stays sticky, clr removes it.
        step(1'b0, '0, 1'b0, 1'b1, 1'b1);
        cfg_len = 16'd4;
        for (int i = 1; i <= 3; i++) step(1'b1, DW'(i), i == 3, 1'b1, 1'b0);
        idle(1);
        check("t4_short_err", 64'(len_err), 64'd1);
        for (int i = 1; i <= 4; i++) step(1'b1, DW'(i), i == 4, 1'b1, 1'b0);
        idle(1);
        check("t4_sticky_err", 64'(len_err), 64'd1);
        step(1'b0, '0, 1'b0, 1'b1, 1'b1);
        check("t4_clr_err", 64'(len_err),    64'd0);
        check("t4_clr_cnt", 64'(sample_cnt), 64'd0);

        // Length-only termination, then tlast-only frame with the check disabled.
        for (int i = 1; i <= 4; i++) step(1'b1, DW'(i), 1'b0, 1'b1, 1'b0);
        idle(1);
        check("t5_len_end_err", 64'(len_err), 64'd1);
        step(1'b0, '0, 1'b0, 1'b1, 1'b1);
        cfg_len = 16'd0;
        for (int i = 1; i <= 7; i++) step(1'b1, DW'(i), i == 7, 1'b1, 1'b0);
        check("t5_cfg0_done", 64'(frame_done), 64'd1);
        idle(1);
        check("t5_cfg0_err", 64'(len_err), 64'd0);

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                case ($urandom_range(0, 3))
                    0:       cfg_len = 16'd0;
                    1:       cfg_len = 16'd3;
                    2:       cfg_len = 16'd4;
                    default: cfg_len = 16'd5;
                endcase
            end
            step(($urandom % 4) != 0, $urandom, $urandom_range(0, 5) == 0,
                 ($urandom % 3) != 0, $urandom_range(0, 199) == 0);
        end
        idle(10);

        // Asynchronous reset with 5 beats buffered mid-frame.
        step(1'b0, '0, 1'b0, 1'b1, 1'b1);
        cfg_len = 16'd0;
        for (int i = 1; i <= 5; i++) step(1'b1, DW'(32'h500 + i), 1'b0, 1'b0, 1'b0);
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b0;
        #2 axis_rst_n = 1'b0;
        #1;
        check("rst_s_tready",   64'(s_if.tready), 64'd1);
        check("rst_m_tvalid",   64'(m_if.tvalid), 64'd0);
        check("rst_m_tdata",    64'(m_if.tdata),  64'd0);
        check("rst_m_tlast",    64'(m_if.tlast),  64'd0);
        check("rst_level",      64'(fifo_level),  64'd0);
        check("rst_sample_cnt", 64'(sample_cnt),  64'd0);
        check("rst_checksum",   64'(checksum),    64'd0);
        check("rst_len_err",    64'(len_err),     64'd0);
        check("rst_frame_done", 64'(frame_done),  64'd0);
        model_reset();
        @(posedge axis_clk);
        #2 axis_rst_n = 1'b1;
        @(posedge axis_clk);
        #1;
        step(1'b1, 32'hAAAA, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hBBBB, 1'b1, 1'b0, 1'b0);
        check("t6_level", 64'(fifo_level), 64'd2);
        idle(4);
        check("t6_sample_cnt", 64'(sample_cnt), 64'd2);
        check("t6_empty",      64'(fifo_level), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
